// File: rtl/usb_fs_nb_out_buf_ctrl.sv
// OUT/SETUP buffer controller: claims a packet buffer, packs engine bytes into
// 32-bit SRAM words, and commits an RX descriptor on ACK (or discards on rollback).
module usb_fs_nb_out_buf_ctrl #(
    parameter int unsigned  NumOutEps      = 12,
    parameter int unsigned  MaxPktSizeByte = 64,
    parameter int unsigned  BufIdW         = 5,
    localparam int unsigned PktW           = $clog2(MaxPktSizeByte)
) (
    input  logic                   clk_48mhz_i,
    input  logic                   rst_ni,
    input  logic                   link_reset_i,
    input  logic [3:0]             out_ep_current_i,
    input  logic                   out_ep_newpkt_i,
    input  logic                   out_ep_data_put_i,
    input  logic [PktW-1:0]        out_ep_put_addr_i,
    input  logic [7:0]             out_ep_data_i,
    input  logic                   out_ep_acked_i,
    input  logic                   out_ep_rollback_i,
    input  logic [NumOutEps-1:0]   out_ep_setup_i,
    output logic [NumOutEps-1:0]   out_ep_full_o,
    input  logic [NumOutEps-1:0]   rx_enable_i,
    input  logic                   av_rvalid_i,
    input  logic [BufIdW-1:0]      av_rdata_i,
    output logic                   av_rready_o,
    output logic                   rx_wvalid_o,
    input  logic                   rx_wready_i,
    output logic [BufIdW+PktW+5:0] rx_wdata_o,
    output logic                   mem_req_o,
    output logic [BufIdW+PktW-3:0] mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic [3:0]             mem_wmask_o
);

    // StIdle: no transfer | StActive: packing bytes | StDrop: NAKing, data ignored
    // StFlush: write partial word | StCommit: offer descriptor to RX FIFO
    typedef enum logic [2:0] {StIdle, StActive, StDrop, StFlush, StCommit} state_e;

    localparam logic [PktW:0] MaxCount = (PktW+1)'(MaxPktSizeByte);

    state_e            state_q;
    logic [BufIdW-1:0] buf_id_q;
    logic [3:0]        ep_q;
    logic              setup_q;
    logic [PktW:0]     count_q;
    logic [31:0]       pack_q, pack_d;
    logic [3:0]        mask_q, mask_d;
    logic [PktW-3:0]   word_q, word_d;
    logic              mem_req_q;
    logic [BufIdW+PktW-3:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wmask_q;
    logic              rx_wvalid_q;

    logic [1:0] lane;
    logic       in_xfer, av_ok, put_act, wr_full, wr_flush;
    logic       cur_setup, cur_enable;

    assign lane     = out_ep_put_addr_i[1:0];
    assign in_xfer  = (state_q == StActive) || (state_q == StFlush) || (state_q == StCommit);
    assign av_ok    = av_rvalid_i && rx_wready_i;
    assign put_act  = (state_q == StActive) && out_ep_data_put_i;
    assign word_d   = put_act ? out_ep_put_addr_i[PktW-1:2] : word_q;
    assign wr_full  = put_act && (lane == 2'd3);
    assign wr_flush = out_ep_acked_i && (mask_d != 4'd0);

    always_comb begin
        cur_setup  = 1'b0;
        cur_enable = 1'b0;
        for (int i = 0; i < NumOutEps; i++) begin
            if (out_ep_current_i == 4'(i)) begin
                cur_setup  = out_ep_setup_i[i];
                cur_enable = rx_enable_i[i];
            end
        end
    end

    // The endpoint owning the current transfer is never reported full to itself.
    always_comb begin
        out_ep_full_o = '0;
        for (int i = 0; i < NumOutEps; i++) begin
            out_ep_full_o[i] = (state_q == StDrop) ||
                               (!(in_xfer && (ep_q == 4'(i))) && (!rx_enable_i[i] || !av_ok));
        end
    end

    always_comb begin
        pack_d = pack_q;
        mask_d = mask_q;
        if (put_act) begin
            pack_d[{lane, 3'b000} +: 8] = out_ep_data_i;
            mask_d[lane]                = 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            buf_id_q    <= '0;
            ep_q        <= '0;
            setup_q     <= 1'b0;
            count_q     <= '0;
            pack_q      <= '0;
            mask_q      <= '0;
            word_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rx_wvalid_q <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            if (link_reset_i) begin
                state_q     <= StIdle;
                pack_q      <= '0;
                mask_q      <= '0;
                rx_wvalid_q <= 1'b0;
            end else if (out_ep_newpkt_i) begin
                state_q     <= (cur_enable && av_ok) ? StActive : StDrop;
                ep_q        <= out_ep_current_i;
                setup_q     <= cur_setup;
                buf_id_q    <= av_rdata_i;
                count_q     <= '0;
                pack_q      <= '0;
                mask_q      <= '0;
                rx_wvalid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StActive: begin
                        if (out_ep_rollback_i) begin
                            state_q <= StIdle;
                            pack_q  <= '0;
                            mask_q  <= '0;
                        end else begin
                            if (put_act) begin
                                word_q <= out_ep_put_addr_i[PktW-1:2];
                                if (count_q != MaxCount) count_q <= count_q + (PktW+1)'(1);
                            end
                            // Full word on lane 3, or the partial word when the ACK arrives.
                            if (wr_full || wr_flush) begin
                                mem_req_q   <= 1'b1;
                                mem_addr_q  <= {buf_id_q, word_d};
                                mem_wdata_q <= pack_d;
                                mem_wmask_q <= mask_d;
                                pack_q      <= '0;
                                mask_q      <= '0;
                            end else begin
                                pack_q <= pack_d;
                                mask_q <= mask_d;
                            end
                            if (out_ep_acked_i) state_q <= StFlush;
                        end
                    end
                    StFlush: begin
                        state_q     <= StCommit;
                        rx_wvalid_q <= 1'b1;
                    end
                    StCommit: begin
                        if (rx_wready_i) begin
                            state_q     <= StIdle;
                            rx_wvalid_q <= 1'b0;
                        end
                    end
                    StDrop: begin
                        if (out_ep_acked_i || out_ep_rollback_i) state_q <= StIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign rx_wvalid_o = rx_wvalid_q;
    assign rx_wdata_o  = rx_wvalid_q ? {setup_q, ep_q, count_q, buf_id_q} : '0;
    assign av_rready_o = rx_wvalid_q && rx_wready_i;

endmodule

// File: tb/tb_usb_fs_nb_out_buf_ctrl.sv
// Bench for usb_fs_nb_out_buf_ctrl: transfer-level reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_usb_fs_nb_out_buf_ctrl;

    localparam int NEP = 12;
    localparam int P_IDLE = 0, P_RECV = 1, P_DROP = 2, P_FLUSH = 3, P_DESC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic link_reset_i;
    logic [3:0] out_ep_current_i;
    logic out_ep_newpkt_i, out_ep_data_put_i, out_ep_acked_i, out_ep_rollback_i;
    logic [5:0] out_ep_put_addr_i;
    logic [7:0] out_ep_data_i;
    logic [NEP-1:0] out_ep_setup_i, out_ep_full_o, rx_enable_i;
    logic av_rvalid_i, av_rready_o, rx_wvalid_o, rx_wready_i, mem_req_o;
    logic [4:0] av_rdata_i;
    logic [16:0] rx_wdata_o;
    logic [8:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0] mem_wmask_o;

    always #5 clk = ~clk;

    usb_fs_nb_out_buf_ctrl dut (
        .clk_48mhz_i(clk), .rst_ni(rst_n), .link_reset_i(link_reset_i),
        .out_ep_current_i(out_ep_current_i), .out_ep_newpkt_i(out_ep_newpkt_i),
        .out_ep_data_put_i(out_ep_data_put_i), .out_ep_put_addr_i(out_ep_put_addr_i),
        .out_ep_data_i(out_ep_data_i), .out_ep_acked_i(out_ep_acked_i),
        .out_ep_rollback_i(out_ep_rollback_i), .out_ep_setup_i(out_ep_setup_i),
        .out_ep_full_o(out_ep_full_o), .rx_enable_i(rx_enable_i),
        .av_rvalid_i(av_rvalid_i), .av_rdata_i(av_rdata_i), .av_rready_o(av_rready_o),
        .rx_wvalid_o(rx_wvalid_o), .rx_wready_i(rx_wready_i), .rx_wdata_o(rx_wdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o)
    );

    // Reference model: packet image as a byte array with "written but not yet
    // stored" flags; expected registered outputs for the cycle after each edge.
    logic [7:0]  m_bytes [64];
    bit          m_vld [64];
    int          phase = P_IDLE;
    logic [3:0]  m_ep = '0;
    logic        m_setup = 1'b0;
    logic [4:0]  m_buf = '0;
    int          m_cnt = 0;
    logic        e_req = 1'b0;
    logic [8:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic [3:0]  e_mask = '0;
    logic        e_wvalid = 1'b0;
    logic [16:0] e_wdata = '0;

    function automatic void clear_vld();
        foreach (m_vld[k]) m_vld[k] = 1'b0;
    endfunction

    function automatic void emit(input int w);
        e_req  = 1'b1;
        e_addr = {m_buf, 4'(w)};
        e_data = '0;
        e_mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (m_vld[4*w+b]) begin
                e_data[8*b +: 8] = m_bytes[4*w+b];
                e_mask[b]        = 1'b1;
                m_vld[4*w+b]     = 1'b0;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            phase = P_IDLE; e_req = 1'b0; e_wvalid = 1'b0; clear_vld();
        end else begin
            e_req = 1'b0;
            if (link_reset_i) begin
                phase = P_IDLE; e_wvalid = 1'b0; clear_vld();
            end else if (out_ep_newpkt_i) begin
                int ep;
                ep = int'(out_ep_current_i);
                m_ep = out_ep_current_i;
                m_setup = (ep < NEP) ? out_ep_setup_i[ep] : 1'b0;
                m_buf = av_rdata_i;
                m_cnt = 0;
                clear_vld();
                e_wvalid = 1'b0;
                phase = (ep < NEP && rx_enable_i[ep] && av_rvalid_i && rx_wready_i) ? P_RECV : P_DROP;
            end else begin
                case (phase)
                    P_RECV: begin
                        if (out_ep_rollback_i) begin
                            phase = P_IDLE; clear_vld();
                        end else begin
                            if (out_ep_data_put_i) begin
                                int a;
                                a = int'(out_ep_put_addr_i);
                                m_bytes[a] = out_ep_data_i;
                                m_vld[a] = 1'b1;
                                if (m_cnt < 64) m_cnt++;
                                if (a % 4 == 3) emit(a / 4);
                            end
                            if (out_ep_acked_i) begin
                                for (int w = 0; w < 16; w++)
                                    if (m_vld[4*w] | m_vld[4*w+1] | m_vld[4*w+2] | m_vld[4*w+3]) emit(w);
                                phase = P_FLUSH;
                            end
                        end
                    end
                    P_FLUSH: begin
                        phase = P_DESC;
                        e_wvalid = 1'b1;
                        e_wdata = {m_setup, m_ep, 7'(m_cnt), m_buf};
                    end
                    P_DESC: if (rx_wready_i) begin phase = P_IDLE; e_wvalid = 1'b0; end
                    P_DROP: if (out_ep_acked_i || out_ep_rollback_i) phase = P_IDLE;
                    default: ;
                endcase
            end
        end
    end

    int errors = 0;
    int checks = 0;
    logic [44:0] wr_log[$];
    logic [16:0] desc_log[$];
    int pops = 0;
    int vcyc = 0;
    logic [4:0] fl_head = 5'd0;
    logic [7:0] tx [80];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [NEP-1:0] ef;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NEP; i++)
                    ef[i] = (phase == P_DROP) ? 1'b1 :
                            ((phase == P_RECV || phase == P_FLUSH || phase == P_DESC) && m_ep == 4'(i)) ? 1'b0 :
                            (!rx_enable_i[i] || !av_rvalid_i || !rx_wready_i);
                chk("out_ep_full", out_ep_full_o, ef);
                chk("av_rready", av_rready_o, (phase == P_DESC) && rx_wready_i);
                chk("mem_req", mem_req_o, e_req);
                if (e_req) begin
                    chk("mem_addr", mem_addr_o, e_addr);
                    chk("mem_wdata", mem_wdata_o, e_data);
                    chk("mem_wmask", mem_wmask_o, e_mask);
                end
                chk("rx_wvalid", rx_wvalid_o, e_wvalid);
                if (e_wvalid) chk("rx_wdata", rx_wdata_o, e_wdata);
                if (mem_req_o) wr_log.push_back({mem_addr_o, mem_wdata_o, mem_wmask_o});
                if (rx_wvalid_o) vcyc++;
                if (av_rready_o) begin
                    pops++;
                    desc_log.push_back(rx_wdata_o);
                    fl_head = fl_head + 5'd1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        out_ep_newpkt_i = 1'b0; out_ep_data_put_i = 1'b0; out_ep_acked_i = 1'b0;
        out_ep_rollback_i = 1'b0; link_reset_i = 1'b0;
    endtask

    task automatic pkt_start(input int ep, input bit setup);
        out_ep_current_i = 4'(ep);
        if (ep < NEP) out_ep_setup_i[ep] = setup;
        av_rdata_i = fl_head;
        out_ep_newpkt_i = 1'b1;
        step();
    endtask

    task automatic put_bytes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            out_ep_data_put_i = 1'b1;
            out_ep_put_addr_i = 6'((i > 63) ? 63 : i);
            out_ep_data_i = tx[i];
            step();
            if (gap > 0) repeat ($urandom_range(0, gap)) step();
        end
    endtask

    task automatic finish_ack(input int stall);
        out_ep_acked_i = 1'b1;
        if (stall > 0) rx_wready_i = 1'b0;
        step();
        step();
        repeat (stall) step();
        rx_wready_i = 1'b1;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nd, np, nv;
        logic [16:0] d;
        rst_n = 1'b0;
        link_reset_i = 1'b0; out_ep_current_i = '0; out_ep_newpkt_i = 1'b0;
        out_ep_data_put_i = 1'b0; out_ep_put_addr_i = '0; out_ep_data_i = '0;
        out_ep_acked_i = 1'b0; out_ep_rollback_i = 1'b0; out_ep_setup_i = '0;
        rx_enable_i = '1; av_rvalid_i = 1'b1; av_rdata_i = '0; rx_wready_i = 1'b1;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_rx_wvalid", rx_wvalid_o, 1'b0);
        chk("rst_av_rready", av_rready_o, 1'b0);
        chk("rst_rx_wdata", rx_wdata_o, 17'd0);
        chk("rst_full", out_ep_full_o, 12'h000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // EP2, buffer 7, five bytes, ACK
        fl_head = 5'd7; nw = wr_log.size(); nd = desc_log.size(); np = pops;
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; tx[4] = 8'h55;
        pkt_start(2, 1'b0); put_bytes(5, 0); finish_ack(0); step();
        chk("t1_nwr", wr_log.size() - nw, 2);
        chk("t1_w0", wr_log[nw], {5'd7, 4'd0, 32'h44332211, 4'hF});
        chk("t1_w1", wr_log[nw+1], {5'd7, 4'd1, 32'h00000055, 4'h1});
        chk("t1_desc", desc_log[nd], {1'b0, 4'd2, 7'd5, 5'd7});
        chk("t1_pops", pops - np, 1);

        // No available buffer on EP1: dropped, everything NAKs
        nw = wr_log.size(); np = pops;
        av_rvalid_i = 1'b0;
        pkt_start(1, 1'b0);
        av_rvalid_i = 1'b1;
        @(negedge clk);
        chk("t2_full_drop", out_ep_full_o, 12'hFFF);
        step();
        put_bytes(3, 0);
        out_ep_rollback_i = 1'b1; step();
        @(negedge clk);
        chk("t2_full_idle", out_ep_full_o, 12'h000);
        step();
        chk("t2_nwr", wr_log.size() - nw, 0);
        chk("t2_pops", pops - np, 0);

        // EP3 eight bytes then rollback; buffer id is reused by the next packet
        fl_head = 5'd9; nw = wr_log.size(); nd = desc_log.size(); np = pops;
        for (int i = 0; i < 8; i++) tx[i] = 8'(8'hA0 + i);
        pkt_start(3, 1'b0); put_bytes(8, 0);
        out_ep_rollback_i = 1'b1; step(); step();
        chk("t3_nwr", wr_log.size() - nw, 2);
        chk("t3_ndesc", desc_log.size() - nd, 0);
        chk("t3_pops", pops - np, 0);
        pkt_start(3, 1'b0); put_bytes(4, 0); finish_ack(0); step();
        d = desc_log[desc_log.size()-1];
        chk("t3_reuse_buf", d[4:0], 5'd9);

        // EP0 SETUP, eight bytes, RX FIFO stalls three cycles
        nd = desc_log.size(); np = pops; nv = vcyc;
        for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
        pkt_start(0, 1'b1); put_bytes(8, 0); finish_ack(3); step();
        chk("t4_valid_cycles", vcyc - nv, 4);
        chk("t4_pops", pops - np, 1);
        chk("t4_desc", desc_log[nd], {1'b1, 4'd0, 7'd8, 5'd10});
        out_ep_setup_i = '0;

        // Zero-length OUT
        nw = wr_log.size(); nd = desc_log.size();
        pkt_start(5, 1'b0); finish_ack(0); step();
        chk("t5_nwr", wr_log.size() - nw, 0);
        chk("t5_desc", desc_log[nd], {1'b0, 4'd5, 7'd0, 5'd11});

        // Link reset after three bytes
        nw = wr_log.size(); nd = desc_log.size(); np = pops;
        pkt_start(4, 1'b0); put_bytes(3, 0);
        rx_enable_i[4] = 1'b0;
        link_reset_i = 1'b1; step();
        @(negedge clk);
        chk("t6_idle_full4", out_ep_full_o[4], 1'b1);
        step(); step();
        rx_enable_i = '1;
        chk("t6_nwr", wr_log.size() - nw, 0);
        chk("t6_ndesc", desc_log.size() - nd, 0);
        chk("t6_pops", pops - np, 0);

        // 70-byte packet saturates at 64
        nw = wr_log.size(); nd = desc_log.size();
        for (int i = 0; i < 70; i++) tx[i] = 8'($urandom);
        pkt_start(6, 1'b0); put_bytes(70, 0); finish_ack(0); step();
        d = desc_log[nd];
        chk("t7_size", d[11:5], 7'd64);
        chk("t7_nwr", wr_log.size() - nw, 22);

        // Randomized traffic against the model
        for (int p = 0; p < 150; p++) begin
            int ep, len, kind;
            ep = $urandom_range(0, 13);
            len = $urandom_range(0, 70);
            kind = $urandom_range(0, 9);
            rx_enable_i = ~(12'($urandom) & 12'($urandom) & 12'($urandom));
            av_rvalid_i = ($urandom_range(0, 9) != 0);
            rx_wready_i = ($urandom_range(0, 9) != 0);
            out_ep_setup_i = 12'($urandom);
            for (int i = 0; i < len; i++) tx[i] = 8'($urandom);
            pkt_start(ep, 1'($urandom));
            av_rvalid_i = 1'b1;
            put_bytes(len, 1);
            if (kind < 6) begin
                finish_ack($urandom_range(0, 3));
            end else if (kind < 8) begin
                out_ep_rollback_i = 1'b1; step();
            end else if (kind == 8) begin
                link_reset_i = 1'b1; step();
            end
            rx_wready_i = 1'b1;
            if (kind != 9) step();
        end
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_fs_nb_out_buf_ctrl.md
Name: usb_fs_nb_out_buf_ctrl

Overview:
Buffer controller behind the non-buffered USB FS OUT/SETUP protocol engine. It claims a packet buffer from the available-buffer FIFO when a transfer starts and packs the engine's byte stream into 32-bit SRAM words. On ACK it commits a descriptor to the RX FIFO; on rollback it discards the data. It also drives the engine's per-endpoint full inputs, so the engine NAKs when no buffer or RX slot exists.

Parameters:
NumOutEps, 12, number of implemented OUT endpoints
MaxPktSizeByte, 64, max packet payload; power of two, >=4
BufIdW, 5, buffer id width
PktW (local), $clog2(MaxPktSizeByte), put address width

Ports:
clk_48mhz_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
link_reset_i  in  1  synchronous bus reset, abort everything
out_ep_current_i  in  4  endpoint of the current transfer
out_ep_newpkt_i  in  1  pulse, token accepted, current/setup valid
out_ep_data_put_i  in  1  pulse, byte valid
out_ep_put_addr_i  in  PktW  byte offset of out_ep_data_i
out_ep_data_i  in  8  payload byte
out_ep_acked_i  in  1  pulse, transfer acknowledged, commit
out_ep_rollback_i  in  1  pulse, discard transfer
out_ep_setup_i  in  NumOutEps  per-EP SETUP flag
out_ep_full_o  out  NumOutEps  per-EP cannot-accept to engine
rx_enable_i  in  NumOutEps  software receive enable per EP
av_rvalid_i  in  1  available-buffer FIFO non-empty
av_rdata_i  in  BufIdW  head buffer id
av_rready_o  out  1  pop available FIFO
rx_wvalid_o  out  1  RX descriptor valid
rx_wready_i  in  1  RX FIFO has space
rx_wdata_o  out  BufIdW+PktW+6  {setup, ep[3:0], size[PktW:0], buf_id}
mem_req_o  out  1  SRAM write strobe; the SRAM accepts it every cycle
mem_addr_o  out  BufIdW+PktW-2  word address {buf_id, put_addr[PktW-1:2]}
mem_wdata_o  out  32  write data; byte lane = put_addr[1:0]
mem_wmask_o  out  4  byte-enable mask

Behaviour:
- Reset: state StIdle; all outputs 0; internal buf_id, ep, setup, byte count, pack word and lane mask cleared. Combinational out_ep_full_o evaluates from inputs, with StIdle rules.
- States: StIdle, StActive, StDrop, StFlush, StCommit.
- out_ep_newpkt_i in any state:
  - Abandons the current transfer: no push, no pop, no flush.
  - Latches ep = out_ep_current_i, setup = out_ep_setup_i[ep], buf_id = av_rdata_i; clears count and mask.
  - Next state is StActive if rx_enable_i[ep] && av_rvalid_i && rx_wready_i, else StDrop.
- out_ep_full_o[i]:
  - StDrop: all ones.
  - StActive/StFlush/StCommit: bit for the latched ep is 0; other bits follow the rule below.
  - Otherwise: !rx_enable_i[i] || !av_rvalid_i || !rx_wready_i.
- StActive, on data_put:
  - Byte goes to pack-word lane put_addr[1:0] and sets that mask bit.
  - Count increments, saturating at MaxPktSizeByte; excess bytes overwrite the last byte.
  - A put to lane 3 issues a write on the next cycle: mem_req_o=1, addr {buf_id, put_addr[PktW-1:2]}, wdata = pack word, wmask = accumulated mask. The mask then clears.
- StActive exits:
  - acked -> StFlush.
  - rollback -> StIdle; pending partial word dropped.
- StFlush (1 cycle): if the mask is non-zero, mem_req_o=1 with the partial word and its mask; -> StCommit.
- StCommit:
  - rx_wvalid_o=1, rx_wdata_o = {setup, ep, count, buf_id}; held stable until rx_wready_i.
  - av_rready_o=1 only in the handshake cycle (rx_wvalid_o && rx_wready_i) -> StIdle.
- StDrop: puts ignored; no mem writes. acked or rollback -> StIdle, no push/pop.
- link_reset_i has priority over everything: -> StIdle same edge. The pending word is discarded, no push/pop; in-flight mem_req_o is still allowed.
- acked or rollback in StIdle: ignored. Simultaneous put and acked in StActive: byte is packed, then flushed.
- Latency: last byte to mem write 1 cycle; acked to descriptor valid 2 cycles.

Test Plan:
- EP2 OUT, buf 7, bytes 11,22,33,44,55 then acked -> mem write addr{7,0} data 0x44332211 mask F; flush addr{7,1} data 0x00000055 mask 1; descriptor {0,2,5,7}; av_rready_o one pulse.
- av_rvalid_i=0 at newpkt on EP1 -> out_ep_full_o all 1; no mem_req_o; rollback returns to StIdle; no push/pop.
- EP3 8 bytes then rollback -> two word writes, no descriptor, no pop; next packet reuses the same buf id.
- EP0 SETUP 8 bytes, rx_wready_i low 3 cycles in StCommit -> rx_wvalid_o high 4 cycles with stable data {1,0,8,id}; av_rready_o only in cycle 4.
- Zero-length OUT acked -> no mem writes; descriptor size 0.
- link_reset_i after 3 bytes -> StIdle next cycle, no flush write; 70-byte packet at Max 64 -> size 64.
